// File: rtl/gray_frame_source.sv
// gray_frame_source: reads a stored grayscale frame from synchronous
// single-port memory and streams it in raster order with row/column tags,
// horizontal blanking between lines and frame start/line end/done markers.
module gray_frame_source #(
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 240,
   parameter int HBLANK       = 4,
   parameter int ADDR_W       = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              gray_valid,
   output logic [7:0]        gray,
   output logic [15:0]       pix_row,
   output logic [15:0]       pix_col,
   output logic              sof,
   output logic              eol,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_BLANK  = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [15:0]       col_reg;
   logic [15:0]       row_reg;
   logic [15:0]       blank_cnt_reg;
   logic              drain_cnt_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              done_reg;
   logic              rd_issue;

   // stage 1: read issued last cycle, with its coordinates
   logic              s1_valid_reg;
   logic [15:0]       s1_row_reg;
   logic [15:0]       s1_col_reg;
   // stage 2: pixel presented to the consumer
   logic              s2_valid_reg;
   logic [7:0]        s2_gray_reg;
   logic [15:0]       s2_row_reg;
   logic [15:0]       s2_col_reg;

   logic last_col;
   logic last_row;
   logic blank_end;
   logic drain_end;

   assign last_col  = (col_reg == 16'(IMAGE_WIDTH - 1));
   assign last_row  = (row_reg == 16'(IMAGE_HEIGHT - 1));
   assign blank_end = (blank_cnt_reg == 16'(HBLANK - 1));
   assign drain_end = drain_cnt_reg;

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state_reg <= S_IDLE;
      else      state_reg <= state_next;
   end

   // next-state logic: a line ends on the read of its last column
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) state_next = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (rd_issue && last_col) begin
               if (last_row)        state_next = S_DRAIN;
               else if (HBLANK > 0) state_next = S_BLANK;
               else                 state_next = S_ACTIVE;
            end
         end
         S_BLANK: begin
            if (blank_end) state_next = S_ACTIVE;
         end
         S_DRAIN: begin
            if (drain_end) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // state-decoded outputs; reads stall immediately on pause
   always_comb begin
      rd_issue = (state_reg == S_ACTIVE) && !pause;
      busy     = (state_reg != S_IDLE);
   end

   assign mem_rd_en = rd_issue;
   assign mem_addr  = addr_reg;
   assign done      = done_reg;

   // raster counters; the address holds on the final read so it never
   // leaves the frame, and is cleared by the next start
   always_ff @(posedge clk) begin
      if (!rst) begin
         col_reg       <= '0;
         row_reg       <= '0;
         addr_reg      <= '0;
         blank_cnt_reg <= '0;
         drain_cnt_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  col_reg       <= '0;
                  row_reg       <= '0;
                  addr_reg      <= '0;
                  blank_cnt_reg <= '0;
                  drain_cnt_reg <= 1'b0;
               end
            end
            S_ACTIVE: begin
               if (rd_issue) begin
                  if (last_col) begin
                     col_reg       <= '0;
                     blank_cnt_reg <= '0;
                     drain_cnt_reg <= 1'b0;
                     if (!last_row) begin
                        addr_reg <= addr_reg + ADDR_W'(1);
                        if (HBLANK == 0) row_reg <= row_reg + 16'd1;
                     end
                  end else begin
                     col_reg  <= col_reg + 16'd1;
                     addr_reg <= addr_reg + ADDR_W'(1);
                  end
               end
            end
            S_BLANK: begin
               blank_cnt_reg <= blank_cnt_reg + 16'd1;
               if (blank_end) row_reg <= row_reg + 16'd1;
            end
            S_DRAIN: begin
               drain_cnt_reg <= drain_cnt_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // single-cycle completion pulse, raised as the drain finishes
   always_ff @(posedge clk) begin
      if (!rst) done_reg <= 1'b0;
      else      done_reg <= (state_reg == S_DRAIN) && drain_end;
   end

   // stage 1 tracks the read whose data the memory returns next cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_reg <= 1'b0;
         s1_row_reg   <= '0;
         s1_col_reg   <= '0;
      end else begin
         s1_valid_reg <= rd_issue;
         s1_row_reg   <= row_reg;
         s1_col_reg   <= col_reg;
      end
   end

   // stage 2 captures returned data; pixel fields hold between pixels
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2_valid_reg <= 1'b0;
         s2_gray_reg  <= '0;
         s2_row_reg   <= '0;
         s2_col_reg   <= '0;
      end else begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_gray_reg <= mem_rd_data;
            s2_row_reg  <= s1_row_reg;
            s2_col_reg  <= s1_col_reg;
         end
      end
   end

   assign gray_valid = s2_valid_reg;
   assign gray       = s2_gray_reg;
   assign pix_row    = s2_row_reg;
   assign pix_col    = s2_col_reg;
   assign sof        = s2_valid_reg && (s2_row_reg == 16'd0) && (s2_col_reg == 16'd0);
   assign eol        = s2_valid_reg && (s2_col_reg == 16'(IMAGE_WIDTH - 1));

endmodule
